// File: rtl/spike_time_encoder_if.sv
// Load channel carrying one spike-time vector into the temporal encoder.
// The producer drives the vector and valid; the encoder answers with ready.
interface spike_time_encoder_if #(
    parameter int unsigned NUM_INPUTS = 16,
    parameter int unsigned TIME_WIDTH = 4
);
    logic [NUM_INPUTS*TIME_WIDTH-1:0] spike_times;
    logic [NUM_INPUTS-1:0]            spike_en;
    logic                             load_valid;
    logic                             load_ready;

    modport master (
        output spike_times,
        output spike_en,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  spike_times,
        input  spike_en,
        input  load_valid,
        output load_ready
    );
endinterface

// File: rtl/spike_time_encoder.sv
// Replays a loaded vector of per-lane spike times as one gamma cycle of pulses,
// with a one-deep shadow so consecutive volleys run back to back.
module spike_time_encoder #(
    parameter  int unsigned GAMMA_CYCLE_WIDTH = 16,
    parameter  int unsigned PULSE_WIDTH       = 8,
    parameter  int unsigned NUM_INPUTS        = 16,
    localparam int unsigned TIME_WIDTH        = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                  aclk,
    input  logic                  rst,
    spike_time_encoder_if.slave   load_if,
    output logic [NUM_INPUTS-1:0] output_spikes,
    output logic                  gamma_start,
    output logic [TIME_WIDTH-1:0] gamma_cnt,
    output logic                  busy
);

    localparam int unsigned VEC_W = NUM_INPUTS * TIME_WIDTH;
    // Wide enough for t + PULSE_WIDTH without wrapping.
    localparam int unsigned CMP_W = TIME_WIDTH + $clog2(PULSE_WIDTH + 1) + 1;
    localparam logic [TIME_WIDTH-1:0] LAST_CNT = TIME_WIDTH'(GAMMA_CYCLE_WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [TIME_WIDTH-1:0]   cnt_q, cnt_d;
    logic [VEC_W-1:0]        act_t_q, act_t_d;
    logic [NUM_INPUTS-1:0]   act_en_q, act_en_d;
    logic [VEC_W-1:0]        shd_t_q, shd_t_d;
    logic [NUM_INPUTS-1:0]   shd_en_q, shd_en_d;
    logic                    shd_full_q, shd_full_d;
    logic                    xfer;
    logic [CMP_W-1:0]        cnt_w;

    assign load_if.load_ready = (state_q == IDLE) || !shd_full_q;
    assign xfer               = load_if.load_valid && load_if.load_ready;

    // State, counter and vector registers.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            act_t_q    <= '0;
            act_en_q   <= '0;
            shd_t_q    <= '0;
            shd_en_q   <= '0;
            shd_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_t_q    <= act_t_d;
            act_en_q   <= act_en_d;
            shd_t_q    <= shd_t_d;
            shd_en_q   <= shd_en_d;
            shd_full_q <= shd_full_d;
        end
    end

    // Next-state: load in IDLE, shadow fill during RUN, promotion at gamma end.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        act_t_d    = act_t_q;
        act_en_d   = act_en_q;
        shd_t_d    = shd_t_q;
        shd_en_d   = shd_en_q;
        shd_full_d = shd_full_q;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    act_t_d  = load_if.spike_times;
                    act_en_d = load_if.spike_en;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (shd_full_q) begin
                        act_t_d    = shd_t_q;
                        act_en_d   = shd_en_q;
                        shd_full_d = 1'b0;
                    end else if (xfer) begin
                        // Shadow empty: the arriving vector goes straight to active.
                        act_t_d  = load_if.spike_times;
                        act_en_d = load_if.spike_en;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + TIME_WIDTH'(1);
                    if (xfer) begin
                        shd_t_d    = load_if.spike_times;
                        shd_en_d   = load_if.spike_en;
                        shd_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign cnt_w       = CMP_W'(cnt_q);
    assign gamma_cnt   = cnt_q;
    assign busy        = (state_q == RUN);
    assign gamma_start = (state_q == RUN) && (cnt_q == '0);

    // Pulse window decode; lanes with t beyond the gamma end never match.
    always_comb begin
        output_spikes = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            output_spikes[i] = (state_q == RUN) && act_en_q[i]
                && (cnt_w >= CMP_W'(act_t_q[i*TIME_WIDTH +: TIME_WIDTH]))
                && (cnt_w <  CMP_W'(act_t_q[i*TIME_WIDTH +: TIME_WIDTH]) + CMP_W'(PULSE_WIDTH));
        end
    end

    // A stalled producer must hold its vector until it is taken.
    ast_hold_while_stalled: assert property (
        @(posedge aclk) disable iff (rst)
        (load_if.load_valid && !load_if.load_ready)
            |=> ($stable(load_if.spike_times) && $stable(load_if.spike_en))
    );

endmodule

// File: tb/tb_spike_time_encoder.sv
// Directed bench: accepted vectors push their expected gamma-cycle trace into a
// scoreboard queue that a negedge monitor drains while the encoder is busy.
module tb_spike_time_encoder;

    localparam int unsigned G  = 16;
    localparam int unsigned PW = 8;
    localparam int unsigned N  = 16;
    localparam int unsigned TW = 4;

    typedef struct {
        int          cnt;
        logic        gs;
        logic [15:0] spk;
    } rec_t;

    logic          aclk;
    logic          rst;
    logic [N-1:0]  output_spikes;
    logic          gamma_start;
    logic [TW-1:0] gamma_cnt;
    logic          busy;

    int   passed = 0;
    int   total  = 0;
    rec_t q[$];

    spike_time_encoder_if #(.NUM_INPUTS(N), .TIME_WIDTH(TW)) lif ();

    spike_time_encoder #(
        .GAMMA_CYCLE_WIDTH(G),
        .PULSE_WIDTH      (PW),
        .NUM_INPUTS       (N)
    ) dut (
        .aclk         (aclk),
        .rst          (rst),
        .load_if      (lif),
        .output_spikes(output_spikes),
        .gamma_start  (gamma_start),
        .gamma_cnt    (gamma_cnt),
        .busy         (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        total++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Expected 16-cycle trace for one vector, straight from the pulse-window rule.
    task automatic push_volley(input logic [63:0] tv, input logic [15:0] en);
        rec_t r;
        int   t;
        for (int c = 0; c < int'(G); c++) begin
            r.cnt = c;
            r.gs  = (c == 0);
            r.spk = '0;
            for (int i = 0; i < int'(N); i++) begin
                t = int'(tv[i*4 +: 4]);
                if (en[i] && c >= t && c < t + int'(PW)) r.spk[i] = 1'b1;
            end
            q.push_back(r);
        end
    endtask

    // Called at a negedge; presents a vector until accepted.
    task automatic send(input logic [63:0] tv, input logic [15:0] en,
                        output int waits, output int acc_cnt);
        lif.spike_times = tv;
        lif.spike_en    = en;
        lif.load_valid  = 1'b1;
        waits   = 0;
        acc_cnt = -1;
        while (!lif.load_ready) begin
            waits++;
            if (waits > 64) begin
                fail("send_accept");
                lif.load_valid = 1'b0;
                return;
            end
            @(negedge aclk);
        end
        acc_cnt = busy ? int'(gamma_cnt) : -1;
        push_volley(tv, en);
        @(posedge aclk);
        #1 lif.load_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int c);
        for (int k = 0; k < 40; k++) begin
            @(negedge aclk);
            if (busy && int'(gamma_cnt) == c) return;
        end
        fail("wait_cnt");
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60; k++) begin
            @(negedge aclk);
            if (!busy) return;
        end
        fail("wait_idle");
    endtask

    // Scoreboard monitor.
    always @(negedge aclk) begin
        if (!rst) begin
            if (busy) begin
                if (q.size() == 0) begin
                    fail("unexpected_volley");
                end else begin
                    rec_t r;
                    r = q.pop_front();
                    check("sb_gamma_cnt", 32'(gamma_cnt), 32'(r.cnt));
                    check("sb_gamma_start", 32'(gamma_start), 32'(r.gs));
                    check("sb_spikes", 32'(output_spikes), 32'(r.spk));
                end
            end else begin
                check("idle_quiet", 32'({output_spikes, gamma_start}), 32'(0));
            end
        end
    end

    initial begin
        int w, a, run;
        rst             = 1'b1;
        lif.spike_times = '0;
        lif.spike_en    = '0;
        lif.load_valid  = 1'b0;
        #1;
        check("rst_spikes", 32'(output_spikes), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_gamma_cnt", 32'(gamma_cnt), 32'(0));
        check("rst_gamma_start", 32'(gamma_start), 32'(0));
        repeat (3) @(negedge aclk);
        #2 rst = 1'b0;
        @(negedge aclk);
        check("idle_ready", 32'(lif.load_ready), 32'(1));

        // Basic volley with a truncated lane.
        send(64'h0000_0000_0000_0C50, 16'h0007, w, a);
        check("t1_idle_accept", 32'(a), 32'(-1));
        wait_cnt(5);
        check("t1_cnt5", 32'(output_spikes), 32'h0003);
        wait_cnt(12);
        check("t1_cnt12", 32'(output_spikes), 32'h0006);
        wait_cnt(15);
        check("t1_cnt15", 32'(output_spikes), 32'h0004);
        @(negedge aclk);
        check("t1_back_idle", 32'({busy, gamma_cnt}), 32'(0));

        // Shadow load, stall of a third vector until promotion.
        send(64'h0123_4567_89AB_CDEF, 16'hA5A5, w, a);
        wait_cnt(3);
        send(64'hFEDC_BA98_7654_3210, 16'h0FF0, w, a);
        check("t2_b_nowait", 32'(w), 32'(0));
        @(negedge aclk);
        check("t2_ready_low_cnt4", 32'(lif.load_ready), 32'(0));
        wait_cnt(6);
        send(64'h3333_0000_7777_1111, 16'hFFFF, w, a);
        check("t2_c_waits", 32'(w), 32'(10));
        check("t2_c_accept_cnt", 32'(a), 32'(0));
        wait_idle();

        // Accept-and-promote on the same boundary edge.
        send({16{4'h8}}, 16'hFFFF, w, a);
        wait_cnt(15);
        send(64'h0, 16'h0001, w, a);
        check("t3_accept_cnt15", 32'(a), 32'(15));
        @(negedge aclk);
        check("t3_gamma_cnt", 32'(gamma_cnt), 32'(0));
        check("t3_busy", 32'(busy), 32'(1));
        check("t3_shadow_empty", 32'(lif.load_ready), 32'(1));
        wait_idle();

        // All lanes disabled: full silent run.
        send(64'h0, 16'h0000, w, a);
        wait_cnt(15);
        @(negedge aclk);
        check("t4_idle_after", 32'(busy), 32'(0));

        // Reset mid-volley with a full shadow.
        send(64'h0, 16'h0001, w, a);
        wait_cnt(2);
        send(64'h5, 16'h0002, w, a);
        wait_cnt(6);
        check("t5_lane0_high", 32'(output_spikes[0]), 32'(1));
        check("t5_shadow_full", 32'(lif.load_ready), 32'(0));
        #2 rst = 1'b1;
        q.delete();
        #1;
        check("t5_async_spikes", 32'(output_spikes), 32'(0));
        check("t5_async_busy", 32'(busy), 32'(0));
        @(negedge aclk);
        #2 rst = 1'b0;
        @(negedge aclk);
        check("t5_ready_after", 32'(lif.load_ready), 32'(1));
        repeat (20) @(negedge aclk);
        check("t5_no_replay", 32'(busy), 32'(0));

        // Abutting pulses across back-to-back volleys.
        send(64'hC, 16'h0001, w, a);
        wait_cnt(5);
        send(64'h0, 16'h0001, w, a);
        wait_cnt(11);
        run = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge aclk);
            if (output_spikes[0]) run++;
            else if (run > 0) break;
        end
        check("t6_abut_run", 32'(run), 32'(12));
        wait_idle();

        repeat (2) @(negedge aclk);
        check("queue_drained", 32'(q.size()), 32'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spike_time_encoder.md
Name: spike_time_encoder

Overview:
- Temporal encoder that produces the spike volleys consumed by the winner-take-all stage.
- Accepts a vector of per-lane spike times through a valid/ready handshake and replays it as one gamma cycle of spike pulses.
- Each lane's pulse rises at its programmed time and lasts PULSE_WIDTH cycles.
- Sits upstream of wta_1; its output_spikes drive wta_1's input_spikes directly.

Parameters:
GAMMA_CYCLE_WIDTH, 16, clock cycles per gamma cycle (>=2)
PULSE_WIDTH, 8, spike pulse length in cycles (>=1)
NUM_INPUTS, 16, number of spike lanes
TIME_WIDTH (localparam), $clog2(GAMMA_CYCLE_WIDTH), width of one spike time and of gamma_cnt

Ports:
aclk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
spike_times  input  NUM_INPUTS*TIME_WIDTH  lane i time at bits [i*TIME_WIDTH +: TIME_WIDTH]
spike_en  input  NUM_INPUTS  lane i spikes this gamma cycle only if 1
load_valid  input  1  spike_times/spike_en valid
load_ready  output  1  encoder can accept a vector
output_spikes  output  NUM_INPUTS  spike pulses to WTA
gamma_start  output  1  high during cycle gamma_cnt==0 while RUN
gamma_cnt  output  TIME_WIDTH  current position in gamma cycle (0 in IDLE)
busy  output  1  state==RUN

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE, gamma_cnt=0, active and shadow registers cleared, shadow_full=0.
  - output_spikes=0, gamma_start=0, busy=0.
  - Handshake inputs are ignored while rst=1.
  - Reset mid-gamma aborts the volley immediately, and any pending vector is discarded.
- Transfer: happens on a rising edge with load_valid && load_ready. Inputs must be held stable while load_valid=1 && load_ready=0.
- load_ready:
  - IDLE: 1.
  - RUN: !shadow_full.
  - Combinational from state and shadow_full only, never from load_valid.
- IDLE:
  - On transfer, capture into the active registers; next cycle state=RUN with gamma_cnt=0.
  - First possible spike (t=0) is therefore 1 cycle after the accepting edge.
- RUN:
  - gamma_cnt increments by 1 each cycle.
  - A transfer in RUN writes the shadow registers and sets shadow_full.
  - At gamma_cnt==GAMMA_CYCLE_WIDTH-1:
    - If shadow_full, or a transfer occurs on this same edge, that vector moves to active, shadow_full clears, gamma_cnt=0, and state stays RUN. Back-to-back gamma cycles have no gap.
    - Otherwise state=IDLE and gamma_cnt=0.
- Simultaneous transfer with promotion at the boundary (shadow empty): the new vector bypasses the shadow straight to active, and shadow_full stays 0.
- output_spikes[i]:
  - Decoded from registered state only (active regs, gamma_cnt, state); no added latency, no combinational path from inputs.
  - Equals (state==RUN) && en[i] && (gamma_cnt >= t[i]) && (gamma_cnt < t[i]+PULSE_WIDTH).
  - Comparison is computed at TIME_WIDTH+1 or wider, so there is no wrap.
  - t[i] >= GAMMA_CYCLE_WIDTH (non-power-of-2 gamma): lane silent.
  - Pulse truncated at gamma end. No carry-over into the next gamma cycle.
  - A lane with t=0 in the next volley re-asserts at cnt 0. Adjacent pulses may abut without a low cycle; this is accepted.
- gamma_start = (state==RUN) && (gamma_cnt==0).
- Only one volley is in flight. Shadow depth is exactly 1 and no vector is ever dropped or duplicated.

Test Plan:
- Reset, then load t={lane0:0, lane1:5, lane2:12, others 0}, en=0x0007 (G=16, PW=8):
  - lane0 high cnt 0..7.
  - lane1 high cnt 5..12.
  - lane2 high cnt 12..15 only (truncated).
  - Lanes 3..15 low.
  - gamma_start pulses once; state returns to IDLE after cnt 15 with busy=0.
- Load A in IDLE, then load B at cnt=3:
  - load_ready falls at cnt 4 and stays 0 until B is promoted.
  - B's gamma_start immediately follows cnt 15 of A (no gap).
  - A third vector presented at cnt 6 is not accepted until B becomes active.
- Load A, then present B only at cnt=15 with shadow empty:
  - B is accepted and promoted the same edge.
  - Next cycle gamma_cnt=0, busy=1, shadow_full=0.
- en=0x0000 with all t=0:
  - Full 16-cycle RUN with gamma_start=1 at cnt 0 and output_spikes=0 throughout.
- Assert rst at cnt=6 with lane0 spiking and shadow_full=1:
  - output_spikes=0 and busy=0 asynchronously.
  - After release, load_ready=1, and no stale volley is replayed without a new load.
- Back-to-back volleys, lane0 t=12 in A and t=0 in B:
  - lane0 is high for cnt 12..15 of A and continuously through cnt 0..7 of B (abutting, 12 cycles total).
